// File: rtl/monitor_rotacao.sv
// Tachometer supervisor: counts debounced tach pulses per 1 Hz window and raises a latched
// stall alarm when the motor is commanded on but stops turning. Optional filter: TACH_FILTER_EN.
module monitor_rotacao #(
  parameter int CNT_W           = 8,
  parameter int DEBOUNCE_CYCLES = 27000,
  parameter int SPINUP_SECONDS  = 2,
  parameter int STALL_SECONDS   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_1hz,
  input  logic             motor_on,
  input  logic             tach_in,
  output logic [CNT_W-1:0] pps,
  output logic             pps_valid,
  output logic             stall_alarm,
  output logic [1:0]       estado
);

  typedef enum logic [1:0] {
    PARADO  = 2'd0,
    PARTIDA = 2'd1,
    GIRANDO = 2'd2,
    TRAVADO = 2'd3
  } estado_t;

  localparam int SPIN_W = (SPINUP_SECONDS < 2) ? 1 : $clog2(SPINUP_SECONDS + 1);
  localparam int MISS_W = (STALL_SECONDS < 2) ? 1 : $clog2(STALL_SECONDS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (SPINUP_SECONDS < 1 || STALL_SECONDS < 1 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("monitor_rotacao: SPINUP_SECONDS, STALL_SECONDS and DEBOUNCE_CYCLES must be >= 1");
  end

  logic tach_s1, tach_s2, tach_filt, tach_filt_d, edge_p;

  always_ff @(posedge clk) begin
    if (reset) begin
      tach_s1     <= 1'b0;
      tach_s2     <= 1'b0;
      tach_filt_d <= 1'b0;
    end else begin
      tach_s1     <= tach_in;
      tach_s2     <= tach_s1;
      tach_filt_d <= tach_filt;
    end
  end

`ifdef TACH_FILTER_EN
  localparam int DEB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  logic [DEB_W-1:0] deb_cnt;
  logic             filt_q;

  // The filtered level flips only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_cnt <= '0;
      filt_q  <= 1'b0;
    end else if (tach_s2 == filt_q) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
      deb_cnt <= '0;
      filt_q  <= tach_s2;
    end else begin
      deb_cnt <= deb_cnt + DEB_W'(1);
    end
  end

  assign tach_filt = filt_q;
`else
  assign tach_filt = tach_s2;
`endif

  assign edge_p = tach_filt & ~tach_filt_d;

  logic [CNT_W-1:0] win_cnt, close_cnt;

  // Count as it stands at the end of this cycle, so an edge on the tick cycle is included.
  assign close_cnt = (edge_p && (win_cnt != CNT_MAX)) ? win_cnt + CNT_W'(1) : win_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt   <= '0;
      pps       <= '0;
      pps_valid <= 1'b0;
    end else begin
      pps_valid <= tick_1hz;
      if (tick_1hz) begin
        pps     <= close_cnt;
        win_cnt <= '0;
      end else begin
        win_cnt <= close_cnt;
      end
    end
  end

  estado_t           state, state_n;
  logic [SPIN_W-1:0] spin_cnt, spin_cnt_n;
  logic [MISS_W-1:0] miss_cnt, miss_cnt_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= PARADO;
      spin_cnt <= '0;
      miss_cnt <= '0;
    end else begin
      state    <= state_n;
      spin_cnt <= spin_cnt_n;
      miss_cnt <= miss_cnt_n;
    end
  end

  // motor_on=0 is checked before the tick so a stop command always beats a stall declaration.
  always_comb begin
    state_n    = state;
    spin_cnt_n = spin_cnt;
    miss_cnt_n = miss_cnt;
    case (state)
      PARADO: begin
        if (motor_on) begin
          state_n    = PARTIDA;
          spin_cnt_n = '0;
        end
      end
      PARTIDA: begin
        if (!motor_on) begin
          state_n = PARADO;
        end else if (tick_1hz) begin
          if (spin_cnt == SPIN_W'(SPINUP_SECONDS - 1)) begin
            state_n    = GIRANDO;
            miss_cnt_n = '0;
          end else begin
            spin_cnt_n = spin_cnt + SPIN_W'(1);
          end
        end
      end
      GIRANDO: begin
        if (!motor_on) begin
          state_n = PARADO;
        end else if (tick_1hz) begin
          if (close_cnt != '0) begin
            miss_cnt_n = '0;
          end else if (miss_cnt == MISS_W'(STALL_SECONDS - 1)) begin
            state_n = TRAVADO;
          end else begin
            miss_cnt_n = miss_cnt + MISS_W'(1);
          end
        end
      end
      TRAVADO: begin
        if (!motor_on) state_n = PARADO;
      end
      default: state_n = PARADO;
    endcase
  end

  always_comb begin
    estado      = state;
    stall_alarm = (state == TRAVADO);
  end

endmodule
